// File: rtl/frame_commit_ctrl_pkg.sv
// Shared display constants and the commit handshake state encoding.
package frame_commit_ctrl_pkg;
    localparam int OLED_W = 96;
    localparam int OLED_H = 64;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ARMED   = ST_ARMED,
        COMMIT  = ST_COMMIT,
        RELEASE = ST_RELEASE
    } state_t;

    localparam logic [7:0] DROP_MAX = 8'd255;
endpackage

// File: rtl/vsync_tick_div.sv
// Frame boundary edge detect, divide-by-FRAME_DIV animation tick and frame counter.
module vsync_tick_div
    import frame_commit_ctrl_pkg::*;
#(
    parameter int FRAME_DIV = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync,
    output logic             tick_int,
    output logic             frame_tick,
    output logic [CNT_W-1:0] frame_count
);
    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

    logic       vsync_d;
    logic [7:0] div_cnt;
    logic       vs_edge;

    // vsync_d resets high so a pulse already in progress at release is ignored
    assign vs_edge  = vsync & ~vsync_d;
    assign tick_int = vs_edge && (div_cnt == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d     <= 1'b1;
            div_cnt     <= '0;
            frame_tick  <= 1'b0;
            frame_count <= '0;
        end else begin
            vsync_d    <= vsync;
            frame_tick <= tick_int;
            if (vs_edge)
                div_cnt <= tick_int ? 8'd0 : 8'(div_cnt + 8'd1);
            if (tick_int)
                frame_count <= frame_count + 1'b1;
        end
    end
endmodule

// File: rtl/frame_commit_ctrl.sv
// Commits staged back-buffer frames only on frame ticks via req/ack, swapping buf_sel.
module frame_commit_ctrl
    import frame_commit_ctrl_pkg::*;
#(
    parameter int FRAME_DIV = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clock_100mhz,
    input  logic             reset,
    input  logic             clock_vsync,
    input  logic             update_req,
    output logic             update_ack,
    output logic             commit,
    output logic             buf_sel,
    output logic             frame_tick,
    output logic [CNT_W-1:0] frame_count,
    output logic [7:0]       drop_count
);
    state_t state, state_n;
    logic   tick_int;

    vsync_tick_div #(.FRAME_DIV(FRAME_DIV), .CNT_W(CNT_W)) u_div (
        .clk         (clock_100mhz),
        .rst         (reset),
        .vsync       (clock_vsync),
        .tick_int    (tick_int),
        .frame_tick  (frame_tick),
        .frame_count (frame_count)
    );

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // A withdrawn request beats a coincident tick: nothing half-committed
    always_comb begin
        state_n    = state;
        commit     = 1'b0;
        update_ack = 1'b0;
        case (state)
            IDLE:    if (update_req) state_n = ARMED;
            ARMED:   if (!update_req) state_n = IDLE;
                     else if (tick_int) state_n = COMMIT;
            COMMIT: begin
                commit     = 1'b1;
                update_ack = 1'b1;
                state_n    = RELEASE;
            end
            RELEASE: if (!update_req) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            buf_sel    <= 1'b0;
            drop_count <= '0;
        end else begin
            if (state == ARMED && state_n == COMMIT)
                buf_sel <= ~buf_sel;
            if (tick_int && state != ARMED && drop_count != DROP_MAX)
                drop_count <= drop_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_frame_commit_ctrl.sv
// Scoreboard bench: stimulus queues expected output events, a monitor pops on every pulse.
module tb_frame_commit_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance a: FRAME_DIV=1, CNT_W=4; instance b: FRAME_DIV=3, CNT_W=16
    logic       rst_a, vs_a, req_a, ack_a, commit_a, buf_a, ft_a;
    logic [3:0] fc_a;
    logic [7:0] drop_a;
    logic        rst_b, vs_b, req_b, ack_b, commit_b, buf_b, ft_b;
    logic [15:0] fc_b;
    logic [7:0]  drop_b;

    frame_commit_ctrl #(.FRAME_DIV(1), .CNT_W(4)) dut_a (
        .clock_100mhz(clk), .reset(rst_a), .clock_vsync(vs_a), .update_req(req_a),
        .update_ack(ack_a), .commit(commit_a), .buf_sel(buf_a), .frame_tick(ft_a),
        .frame_count(fc_a), .drop_count(drop_a)
    );

    frame_commit_ctrl #(.FRAME_DIV(3), .CNT_W(16)) dut_b (
        .clock_100mhz(clk), .reset(rst_b), .clock_vsync(vs_b), .update_req(req_b),
        .update_ack(ack_b), .commit(commit_b), .buf_sel(buf_b), .frame_tick(ft_b),
        .frame_count(fc_b), .drop_count(drop_b)
    );

    typedef struct packed {
        logic        ft;
        logic        commit;
        logic        ack;
        logic        buf_sel;
        logic [15:0] fc;
        logic [7:0]  drop;
    } snap_t;

    snap_t q_a[$];
    snap_t q_b[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_a(input logic c, input logic b, input int fc, input int drop);
        snap_t s;
        s = {1'b1, c, c, b, 16'(fc), 8'(drop)};
        q_a.push_back(s);
    endtask

    task automatic push_b(input int fc, input int drop);
        snap_t s;
        s = {1'b1, 1'b0, 1'b0, 1'b0, 16'(fc), 8'(drop)};
        q_b.push_back(s);
    endtask

    task automatic pulse_a(input int w, input int g);
        vs_a = 1'b1;
        cyc(w);
        vs_a = 1'b0;
        cyc(g);
    endtask

    // monitor: any tick/commit/ack pulse must match the next queued expectation
    always @(negedge clk) begin
        snap_t s, e;
        if (!rst_a && (ft_a || commit_a || ack_a)) begin
            s = {ft_a, commit_a, ack_a, buf_a, 16'(fc_a), drop_a};
            if (q_a.size() == 0) cmp("a_unexpected_event", 32'(s), 32'h0);
            else begin
                e = q_a.pop_front();
                cmp("a_event", 32'(s), 32'(e));
            end
        end
        if (!rst_b && (ft_b || commit_b || ack_b)) begin
            s = {ft_b, commit_b, ack_b, buf_b, fc_b, drop_b};
            if (q_b.size() == 0) cmp("b_unexpected_event", 32'(s), 32'h0);
            else begin
                e = q_b.pop_front();
                cmp("b_event", 32'(s), 32'(e));
            end
        end
    end

    initial begin
        rst_a = 1'b1; vs_a = 1'b1; req_a = 1'b0;
        rst_b = 1'b1; vs_b = 1'b0; req_b = 1'b0;
        cyc(2);
        #3;
        cmp("a_reset_state", 32'({ft_a, commit_a, ack_a, buf_a, fc_a, drop_a}), 32'h0);
        cmp("b_reset_state", 32'({ft_b, commit_b, ack_b, buf_b, fc_b, drop_b}), 32'h0);
        cyc(1);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // vsync high through reset release: no edge
        cyc(10);
        vs_a = 1'b0;
        cyc(3);
        push_a(1'b0, 1'b0, 1, 1);
        pulse_a(5, 10);

        // request held across three ticks: exactly one commit on the first
        req_a = 1'b1;
        cyc(20);
        push_a(1'b1, 1'b1, 2, 1);
        pulse_a(5, 10);
        push_a(1'b0, 1'b1, 3, 2);
        pulse_a(5, 10);
        push_a(1'b0, 1'b1, 4, 3);
        pulse_a(5, 10);
        req_a = 1'b0;
        cyc(3);

        // request rises on the tick cycle: that tick is dropped, next one commits
        push_a(1'b0, 1'b1, 5, 4);
        vs_a = 1'b1;
        req_a = 1'b1;
        cyc(5);
        vs_a = 1'b0;
        cyc(10);
        push_a(1'b1, 1'b0, 6, 4);
        pulse_a(5, 10);
        req_a = 1'b0;
        cyc(3);

        // reset asserted during the COMMIT cycle
        req_a = 1'b1;
        cyc(3);
        push_a(1'b1, 1'b1, 7, 4);
        vs_a = 1'b1;
        cyc(1);
        #2 rst_a = 1'b1;
        #1;
        cmp("a_reset_in_commit", 32'({ft_a, commit_a, ack_a, buf_a, fc_a, drop_a}), 32'h0);
        vs_a = 1'b0;
        cyc(2);
        req_a = 1'b0;
        cyc(1);
        rst_a = 1'b0;
        cyc(3);
        push_a(1'b0, 1'b0, 1, 1);
        pulse_a(5, 10);
        cmp("a_buf_after_reset", 32'(buf_a), 32'h0);
        req_a = 1'b1;
        cyc(3);
        push_a(1'b1, 1'b1, 2, 1);
        pulse_a(5, 10);
        req_a = 1'b0;
        cyc(3);

        // 300 idle ticks: 4-bit frame_count wraps, drop_count saturates
        rst_a = 1'b1;
        cyc(2);
        rst_a = 1'b0;
        cyc(2);
        for (int i = 1; i <= 300; i++) begin
            push_a(1'b0, 1'b0, i % 16, (i > 255) ? 255 : i);
            pulse_a(2, 2);
            if (i == 17) cmp("a_fc_wrap_17", 32'(fc_a), 32'd1);
        end
        cyc(3);
        cmp("a_fc_after_300", 32'(fc_a), 32'd12);
        cmp("a_drop_saturated", 32'(drop_a), 32'd255);

        // divide by 3: ticks only after edges 3 and 6
        for (int i = 1; i <= 7; i++) begin
            if (i % 3 == 0) push_b(i / 3, i / 3);
            vs_b = 1'b1;
            cyc(5);
            vs_b = 1'b0;
            cyc(5);
        end
        cyc(2);
        cmp("b_frame_count", 32'(fc_b), 32'd2);
        cmp("b_drop_count", 32'(drop_b), 32'd2);
        cmp("b_buf_sel", 32'(buf_b), 32'd0);

        cmp("a_events_outstanding", 32'(q_a.size()), 32'd0);
        cmp("b_events_outstanding", 32'(q_b.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
